// File: rtl/cacc_calc_seq.sv
// Sequencer for one int8 CACC accumulate/round slice: issues MAC beats to the add/sat/round datapath,
// manages the 34-bit partial buffer, and stalls the MAC stream on read-after-write hazards.
// Optional macro CACC_SEQ_SAT_CNT_EN enables the saturated-final counter on sat_cnt.
module cacc_calc_seq #(
    parameter int ENTRY_AW = 5,
    parameter int OP_CW    = 8
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic [ENTRY_AW-1:0] cfg_stripe_len,
    input  logic [OP_CW-1:0]    cfg_op_num,
    input  logic                cfg_start,
    output logic                busy,
    output logic                done,
    input  logic                mac_valid,
    output logic                mac_ready,
    input  logic [21:0]         mac_data,
    output logic                abuf_rd_en,
    output logic [ENTRY_AW-1:0] abuf_rd_addr,
    input  logic [33:0]         abuf_rd_data,
    output logic                calc_in_valid,
    output logic                calc_in_sel,
    output logic                calc_in_op_valid,
    output logic [21:0]         calc_in_data,
    output logic [33:0]         calc_in_op,
    input  logic                calc_out_partial_valid,
    input  logic [33:0]         calc_out_partial_data,
    input  logic                calc_out_final_valid,
    input  logic [31:0]         calc_out_final_data,
    input  logic                calc_out_final_sat,
    output logic                abuf_wr_en,
    output logic [ENTRY_AW-1:0] abuf_wr_addr,
    output logic [33:0]         abuf_wr_data,
    output logic                dlv_valid,
    output logic [31:0]         dlv_data,
    output logic [ENTRY_AW-1:0] dlv_addr,
    output logic [15:0]         sat_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    typedef struct packed {
        logic                vld;
        logic [ENTRY_AW-1:0] addr;
        logic                first;
        logic                last;
    } tag_t;

    localparam logic [ENTRY_AW-1:0] ENT_ONE = 1;
    localparam logic [OP_CW-1:0]    OP_ONE  = 1;

    state_e              state_q, state_d;
    logic [ENTRY_AW-1:0] stripe_len_q, stripe_len_d;
    logic [OP_CW-1:0]    op_num_q, op_num_d;
    logic [ENTRY_AW-1:0] ent_q, ent_d;
    logic [OP_CW-1:0]    op_q, op_d;
    tag_t                s1_q, s2_q, s3_q, tag_new;
    logic [21:0]         data_q;

    logic ent_last, op_last, rd_need, hazard, accept, pipe_empty;

    assign ent_last   = (ent_q == stripe_len_q);
    assign op_last    = (op_q == op_num_q);
    assign rd_need    = (op_q != '0);
    assign pipe_empty = !(s1_q.vld | s2_q.vld | s3_q.vld);

    // A non-last tag in flight will write its entry back; a read of that entry must wait.
    assign hazard = rd_need &
                    ((s1_q.vld & !s1_q.last & (s1_q.addr == ent_q)) |
                     (s2_q.vld & !s2_q.last & (s2_q.addr == ent_q)) |
                     (s3_q.vld & !s3_q.last & (s3_q.addr == ent_q)));

    assign mac_ready = (state_q == ST_RUN) & !hazard;
    assign accept    = mac_valid & mac_ready;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        tag_new       = '0;
        tag_new.vld   = accept;
        tag_new.addr  = ent_q;
        tag_new.first = !rd_need;
        tag_new.last  = op_last;
    end

    always_comb begin
        state_d      = state_q;
        stripe_len_d = stripe_len_q;
        op_num_d     = op_num_q;
        ent_d        = ent_q;
        op_d         = op_q;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d      = ST_RUN;
                    stripe_len_d = cfg_stripe_len;
                    op_num_d     = cfg_op_num;
                    ent_d        = '0;
                    op_d         = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (ent_last) begin
                        ent_d = '0;
                        op_d  = op_q + OP_ONE;
                        if (op_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        ent_d = ent_q + ENT_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= ST_IDLE;
            stripe_len_q <= '0;
            op_num_q     <= '0;
            ent_q        <= '0;
            op_q         <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            stripe_len_q <= stripe_len_d;
            op_num_q     <= op_num_d;
            ent_q        <= ent_d;
            op_q         <= op_d;
            s1_q         <= tag_new;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            if (accept) begin
                data_q <= mac_data;
            end
        end
    end

    assign abuf_rd_en   = accept & rd_need;
    assign abuf_rd_addr = ent_q;

    assign calc_in_valid    = s1_q.vld;
    assign calc_in_data     = data_q;
    assign calc_in_op_valid = s1_q.vld & !s1_q.first;
    assign calc_in_op       = calc_in_op_valid ? abuf_rd_data : '0;
    assign calc_in_sel      = s1_q.vld & s1_q.last;

    // Datapath results are only honoured while a live tag sits in stage 3.
    assign abuf_wr_en   = s3_q.vld & calc_out_partial_valid;
    assign abuf_wr_addr = s3_q.addr;
    assign abuf_wr_data = abuf_wr_en ? calc_out_partial_data : '0;

    assign dlv_valid = s3_q.vld & calc_out_final_valid;
    assign dlv_data  = dlv_valid ? calc_out_final_data : '0;
    assign dlv_addr  = s3_q.addr;

`ifdef CACC_SEQ_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if ((state_q == ST_IDLE) && cfg_start) begin
            sat_cnt_d = '0;
        end else if (dlv_valid && calc_out_final_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_final_sat;
    assign unused_final_sat = calc_out_final_sat;
    assign sat_cnt          = '0;
`endif

endmodule

// File: tb/tb_cacc_calc_seq.sv
// Directed bench for cacc_calc_seq with a behavioural abuf memory and 2-stage add/sat datapath.
module tb_cacc_calc_seq;

    localparam int AW = 5;
    localparam int CW = 8;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rst;
    logic [AW-1:0] cfg_stripe_len;
    logic [CW-1:0] cfg_op_num;
    logic          cfg_start;
    logic          busy, done;
    logic          mac_valid, mac_ready;
    logic [21:0]   mac_data;
    logic          abuf_rd_en;
    logic [AW-1:0] abuf_rd_addr;
    logic [33:0]   abuf_rd_data;
    logic          calc_in_valid, calc_in_sel, calc_in_op_valid;
    logic [21:0]   calc_in_data;
    logic [33:0]   calc_in_op;
    logic          calc_out_partial_valid;
    logic [33:0]   calc_out_partial_data;
    logic          calc_out_final_valid;
    logic [31:0]   calc_out_final_data;
    logic          calc_out_final_sat;
    logic          abuf_wr_en;
    logic [AW-1:0] abuf_wr_addr;
    logic [33:0]   abuf_wr_data;
    logic          dlv_valid;
    logic [31:0]   dlv_data;
    logic [AW-1:0] dlv_addr;
    logic [15:0]   sat_cnt;

    cacc_calc_seq #(.ENTRY_AW(AW), .OP_CW(CW)) dut (
        .nvdla_core_clk        (nvdla_core_clk),
        .nvdla_core_rst        (nvdla_core_rst),
        .cfg_stripe_len        (cfg_stripe_len),
        .cfg_op_num            (cfg_op_num),
        .cfg_start             (cfg_start),
        .busy                  (busy),
        .done                  (done),
        .mac_valid             (mac_valid),
        .mac_ready             (mac_ready),
        .mac_data              (mac_data),
        .abuf_rd_en            (abuf_rd_en),
        .abuf_rd_addr          (abuf_rd_addr),
        .abuf_rd_data          (abuf_rd_data),
        .calc_in_valid         (calc_in_valid),
        .calc_in_sel           (calc_in_sel),
        .calc_in_op_valid      (calc_in_op_valid),
        .calc_in_data          (calc_in_data),
        .calc_in_op            (calc_in_op),
        .calc_out_partial_valid(calc_out_partial_valid),
        .calc_out_partial_data (calc_out_partial_data),
        .calc_out_final_valid  (calc_out_final_valid),
        .calc_out_final_data   (calc_out_final_data),
        .calc_out_final_sat    (calc_out_final_sat),
        .abuf_wr_en            (abuf_wr_en),
        .abuf_wr_addr          (abuf_wr_addr),
        .abuf_wr_data          (abuf_wr_data),
        .dlv_valid             (dlv_valid),
        .dlv_data              (dlv_data),
        .dlv_addr              (dlv_addr),
        .sat_cnt               (sat_cnt)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Behavioural accumulator buffer and datapath
    logic [33:0] mem [0:(1<<AW)-1];
    logic        pre_en;
    logic [33:0] pre_dat;
    logic        p1_vld, p1_sel, p1_sat, p2_vld, p2_sel, p2_sat;
    logic [33:0] p1_part, p2_part;
    logic [31:0] p1_fin, p2_fin;
    logic signed [34:0] dp_sum;

    always_comb begin
        dp_sum = $signed({{13{calc_in_data[21]}}, calc_in_data});
        if (calc_in_op_valid) dp_sum = dp_sum + $signed({calc_in_op[33], calc_in_op});
    end

    always @(posedge nvdla_core_clk) begin
        if (abuf_wr_en) mem[abuf_wr_addr] <= abuf_wr_data;
        if (pre_en) mem[0] <= pre_dat;
        if (abuf_rd_en) abuf_rd_data <= mem[abuf_rd_addr];
        if (nvdla_core_rst) begin
            p1_vld <= 1'b0;
            p2_vld <= 1'b0;
        end else begin
            p1_vld  <= calc_in_valid;
            p1_sel  <= calc_in_sel;
            p1_part <= dp_sum[33:0];
            if (dp_sum > 35'sh7FFFFFFF) begin
                p1_fin <= 32'h7FFFFFFF; p1_sat <= 1'b1;
            end else if (dp_sum < -35'sh80000000) begin
                p1_fin <= 32'h80000000; p1_sat <= 1'b1;
            end else begin
                p1_fin <= dp_sum[31:0]; p1_sat <= 1'b0;
            end
            p2_vld <= p1_vld; p2_sel <= p1_sel; p2_part <= p1_part;
            p2_fin <= p1_fin; p2_sat <= p1_sat;
        end
    end

    assign calc_out_partial_valid = p2_vld & !p2_sel;
    assign calc_out_partial_data  = p2_part;
    assign calc_out_final_valid   = p2_vld & p2_sel;
    assign calc_out_final_data    = p2_fin;
    assign calc_out_final_sat     = p2_sat;

    // Event logs sampled on the falling edge
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int          dlv_cyc[$], wr_cyc[$], rd_cyc[$], ci_cyc[$];
    logic [31:0] dlv_dat[$];
    logic [AW-1:0] dlv_adr[$], wr_adr[$], rd_adr[$];
    logic [33:0] wr_dat[$];

    always @(posedge nvdla_core_clk) cyc <= cyc + 1;

    always @(negedge nvdla_core_clk) begin
        if (dlv_valid)     begin dlv_cyc.push_back(cyc); dlv_dat.push_back(dlv_data); dlv_adr.push_back(dlv_addr); end
        if (abuf_wr_en)    begin wr_cyc.push_back(cyc); wr_dat.push_back(abuf_wr_data); wr_adr.push_back(abuf_wr_addr); end
        if (abuf_rd_en)    begin rd_cyc.push_back(cyc); rd_adr.push_back(abuf_rd_addr); end
        if (calc_in_valid) ci_cyc.push_back(cyc);
        if (done)          begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    end

    int checks = 0, failures = 0, stalls = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] len, input logic [CW-1:0] opn);
        cfg_stripe_len = len;
        cfg_op_num     = opn;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic send(input logic [21:0] d, output int acc);
        int g;
        g = 0;
        mac_valid = 1'b1;
        mac_data  = d;
        @(negedge nvdla_core_clk);
        while (!mac_ready && g < 50) begin
            stalls++;
            g++;
            @(negedge nvdla_core_clk);
        end
        if (g >= 50) chk("accept_timeout", 0, 1);
        acc = cyc;
        tick();
        mac_valid = 1'b0;
    endtask

    task automatic wait_done();
        int s, g;
        s = done_cnt;
        g = 0;
        while (done_cnt == s && g < 100) begin
            @(negedge nvdla_core_clk);
            g++;
        end
        chk("done_seen", (done_cnt != s), 1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc[4];
        int a;
        int b_dlv, b_wr, b_rd, b_ci, b_done;
        int wc, pc;
        nvdla_core_rst = 1'b1;
        cfg_stripe_len = '0;
        cfg_op_num     = '0;
        cfg_start      = 1'b0;
        mac_valid      = 1'b0;
        mac_data       = '0;
        pre_en         = 1'b0;
        pre_dat        = '0;
        repeat (2) tick();
        @(negedge nvdla_core_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_ready", mac_ready, 0);
        chk("rst_rd_en", abuf_rd_en, 0);
        chk("rst_wr_en", abuf_wr_en, 0);
        chk("rst_calc_in", {calc_in_valid, calc_in_sel, calc_in_op_valid}, 0);
        chk("rst_dlv_valid", dlv_valid, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_data_addr", {calc_in_data, abuf_wr_addr, abuf_wr_data, dlv_data, dlv_addr, abuf_rd_addr}, 0);
        tick();
        nvdla_core_rst = 1'b0;
        tick();

        // op_num = 0: single pass, no buffer traffic
        b_dlv = dlv_dat.size(); b_wr = wr_dat.size(); b_rd = rd_adr.size(); b_ci = ci_cyc.size();
        start(3, 0);
        @(negedge nvdla_core_clk);
        chk("t1_busy_after_start", busy, 1);
        tick();
        for (int i = 0; i < 4; i++) send(22'(i + 1), acc[i]);
        wait_done();
        chk("t1_dlv_count", dlv_dat.size() - b_dlv, 4);
        for (int i = 0; i < 4; i++) begin
            if (dlv_dat.size() > b_dlv + i) begin
                chk("t1_dlv_data", dlv_dat[b_dlv + i], 32'(i + 1));
                chk("t1_dlv_addr", dlv_adr[b_dlv + i], AW'(i));
                chk("t1_dlv_latency", dlv_cyc[b_dlv + i], acc[i] + 3);
            end
        end
        chk("t1_calc_in_latency", ci_cyc[b_ci], acc[0] + 1);
        chk("t1_no_writes", wr_dat.size() - b_wr, 0);
        chk("t1_no_reads", rd_adr.size() - b_rd, 0);
        chk("t1_done_latency", done_cyc, acc[3] + 4);
        chk("t1_idle_busy", busy, 0);

        // Two-entry stripe, three ops: hazard stalls expected
        b_dlv = dlv_dat.size(); b_wr = wr_dat.size(); b_rd = rd_adr.size();
        stalls = 0;
        start(1, 2);
        for (int i = 0; i < 6; i++) send(22'd5, a);
        wait_done();
        chk("t2_stalled", (stalls > 0), 1);
        chk("t2_wr_count", wr_dat.size() - b_wr, 4);
        if (wr_dat.size() >= b_wr + 4) begin
            chk("t2_wr0", wr_dat[b_wr + 0], 34'd5);
            chk("t2_wr1", wr_dat[b_wr + 1], 34'd5);
            chk("t2_wr2", wr_dat[b_wr + 2], 34'd10);
            chk("t2_wr3", wr_dat[b_wr + 3], 34'd10);
            chk("t2_wr_addrs", {wr_adr[b_wr], wr_adr[b_wr+1], wr_adr[b_wr+2], wr_adr[b_wr+3]},
                {5'd0, 5'd1, 5'd0, 5'd1});
        end
        chk("t2_dlv_count", dlv_dat.size() - b_dlv, 2);
        if (dlv_dat.size() >= b_dlv + 2) begin
            chk("t2_dlv0", dlv_dat[b_dlv], 32'd15);
            chk("t2_dlv1", dlv_dat[b_dlv + 1], 32'd15);
        end
        chk("t2_rd_count", rd_adr.size() - b_rd, 4);
        for (int i = b_rd; i < rd_adr.size(); i++) begin
            wc = 0; pc = 0;
            for (int j = b_wr; j < wr_dat.size(); j++)
                if (wr_adr[j] == rd_adr[i] && wr_cyc[j] < rd_cyc[i]) wc++;
            for (int j = b_rd; j < i; j++)
                if (rd_adr[j] == rd_adr[i]) pc++;
            chk("t2_read_after_write", wc, pc + 1);
        end

        // Saturation on final
        b_dlv = dlv_dat.size(); b_wr = wr_dat.size();
        start(0, 1);
        send(22'h1FFFFF, a);
        repeat (6) tick();
        chk("t3_first_partial", wr_dat[b_wr], 34'h1FFFFF);
        pre_dat = 34'h1FFFFFFFF;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
        send(22'h1FFFFF, a);
        wait_done();
        chk("t3_dlv_count", dlv_dat.size() - b_dlv, 1);
        chk("t3_sat_final", dlv_dat[b_dlv], 32'h7FFFFFFF);
`ifdef CACC_SEQ_SAT_CNT_EN
        chk("t3_sat_cnt", sat_cnt, 1);
`else
        chk("t3_sat_cnt", sat_cnt, 0);
`endif

        // Start while busy is ignored
        b_dlv = dlv_dat.size(); b_done = done_cnt;
        start(1, 0);
        send(22'd7, a);
        cfg_stripe_len = 5;
        cfg_op_num     = 3;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
        send(22'd8, a);
        wait_done();
        repeat (8) tick();
        chk("t4_single_done", done_cnt - b_done, 1);
        chk("t4_dlv_count", dlv_dat.size() - b_dlv, 2);
        chk("t4_dlv_last", {dlv_adr[b_dlv + 1], dlv_dat[b_dlv + 1]}, {5'd1, 32'd8});
        @(negedge nvdla_core_clk);
        chk("t4_idle_ready", {busy, mac_ready}, 0);
        chk("t4_sat_cleared", sat_cnt, 0);
        tick();

        // Reset with beats in flight
        b_dlv = dlv_dat.size(); b_wr = wr_dat.size(); b_done = done_cnt;
        start(3, 0);
        send(22'd1, a);
        send(22'd2, a);
        nvdla_core_rst = 1'b1;
        tick();
        nvdla_core_rst = 1'b0;
        @(negedge nvdla_core_clk);
        chk("t5_busy", busy, 0);
        chk("t5_ready", mac_ready, 0);
        chk("t5_calc_in", {calc_in_valid, calc_in_sel, calc_in_op_valid}, 0);
        chk("t5_outs", {dlv_valid, abuf_wr_en, abuf_rd_en, done}, 0);
        repeat (8) tick();
        chk("t5_no_dlv", dlv_dat.size() - b_dlv, 0);
        chk("t5_no_wr", wr_dat.size() - b_wr, 0);
        chk("t5_no_done", done_cnt - b_done, 0);

        // Eight entries, four ops, gapped valid; beat k carries k-10 so entry e sums to 4e+8
        b_dlv = dlv_dat.size();
        start(7, 3);
        for (int k = 0; k < 32; k++) begin
            send(22'(k - 10), a);
            tick();
        end
        wait_done();
        chk("t6_dlv_count", dlv_dat.size() - b_dlv, 8);
        for (int e = 0; e < 8; e++) begin
            if (dlv_dat.size() > b_dlv + e) begin
                chk("t6_dlv_data", dlv_dat[b_dlv + e], 32'(4 * e + 8));
                chk("t6_dlv_addr", dlv_adr[b_dlv + e], AW'(e));
            end
        end
        chk("t6_sat_cnt", sat_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
